// File: rtl/main_module_unit.sv
// main_module_unit
//   Sums N_WORDS consecutive entries of an internal 16x16 constant table
//   (mem[i] = 10*(i+1)), starting at a latched 4-bit address that wraps
//   modulo 16, then presents the sum on `out` and flags completion on `done`.
//
// Parameters
//   N_WORDS        words summed per operation (1..16)
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   start          level request, sampled only in IDLE
//   start_address  first table address, sampled on the accepting edge
//   done           completion flag (registered)
//   out            last completed sum; holds until the next completion
//
// Build option
//   DONE_HOLD_EN   when defined, DONE is held while `start` stays high and is
//                  left only once `start` is 0; when undefined, `done` is a
//                  one-cycle pulse followed by an automatic return to IDLE.
module main_module_unit #(
  parameter int unsigned N_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  start_address,
  output logic        done,
  output logic [15:0] out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] LAST_CNT = 5'(N_WORDS - 1);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [3:0]  addr;
  logic [4:0]  cnt;
  logic [15:0] acc;
  logic [15:0] rom_word;
  logic [15:0] sum;
  logic        last;

  function automatic logic [15:0] rom(input logic [3:0] a);
    rom = ({12'd0, a} + 16'd1) * 16'd10;
  endfunction

  always_comb begin
    rom_word = rom(addr);
    sum      = acc + rom_word;
    last     = (cnt == LAST_CNT);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_ACC;
      S_ACC:  if (last)  state_next = S_DONE;
`ifdef DONE_HOLD_EN
      S_DONE: if (!start) state_next = S_IDLE;
`else
      S_DONE: state_next = S_IDLE;
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // done is registered from the next-state decode so it is high exactly
  // while the state register holds DONE, with no combinational glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      addr  <= '0;
      cnt   <= '0;
      acc   <= '0;
      out   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            addr <= start_address;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        S_ACC: begin
          acc  <= sum;
          addr <= addr + 4'd1;
          cnt  <= cnt + 5'd1;
          if (last) out <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_module_unit.sv
// Testbench for main_module_unit (N_WORDS = 4). Table-driven vectors,
// randomized operations against a plain-arithmetic reference, and hand
// sequences for back-to-back operation, wrap-around and asynchronous reset.
module tb_main_module_unit;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  start_address;
  logic        done;
  logic [15:0] out;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  main_module_unit #(.N_WORDS(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .start_address (start_address),
    .done          (done),
    .out           (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] exp_out;
  } vec_t;

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: sum of 10*(table index + 1) over N consecutive wrapped addresses.
  function automatic int unsigned ref_sum(input int unsigned a);
    int unsigned s = 0;
    for (int unsigned k = 0; k < N; k++) s += 10 * (((a + k) % 16) + 1);
    return s % 65536;
  endfunction

  // One complete operation with start raised for the accepting edge only.
  task automatic do_op(input logic [3:0] a, input int unsigned exp, input string name);
    int unsigned k = 0;
    @(negedge clk);
    start = 1'b1;
    start_address = a;
    @(posedge clk); #1;
    start = 1'b0;
    start_address = ~a;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_latency"}, k, N);
    check({name, "_out"}, out, exp);
    @(posedge clk); #1;
    check({name, "_done_low"}, done, 0);
    check({name, "_out_hold"}, out, exp);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4'd2,  16'd180};
    vecs[1] = '{4'd14, 16'd340};
    vecs[2] = '{4'd4,  16'd260};
    vecs[3] = '{4'd5,  16'd300};
    vecs[4] = '{4'd0,  16'd100};
    vecs[5] = '{4'd13, 16'd460};
    vecs[6] = '{4'd15, 16'd220};

    reset = 1'b1;
    start = 1'b0;
    start_address = 4'd0;
    #3;
    check("reset_out", out, 0);
    check("reset_done", done, 0);
    #7;
    reset = 1'b0;

    // Idle with start low: nothing happens.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_done", done, 0);
      check("idle_out", out, 0);
    end

    foreach (vecs[i]) do_op(vecs[i].addr, vecs[i].exp_out, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      do_op(a, ref_sum(a), $sformatf("rand%0d_a%0d", i, a));
    end

`ifndef DONE_HOLD_EN
    // start held high, address changed mid-run: 6-cycle period, one pulse per run.
    @(negedge clk);
    start = 1'b1;
    start_address = 4'd2;
    @(posedge clk); #1;                      // E0 accepts address 2
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) start_address = 4'd5;
      check($sformatf("b2b_done_e%0d", i), done, (i == 4 || i == 10) ? 1 : 0);
      if (i >= 4 && i < 10) check($sformatf("b2b_out_e%0d", i), out, 180);
      if (i >= 10)          check($sformatf("b2b_out_e%0d", i), out, 300);
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) @(posedge clk);
    #1;
    check("b2b_settle_done", done, 0);
`else
    // Hold mode: done stays high while start is high, drops once start falls.
    @(negedge clk);
    start = 1'b1;
    start_address = 4'd2;
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
    end
    check("hold_done_rise", done, 1);
    check("hold_out", out, 180);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("hold_done_stay", done, 1);
      check("hold_out_stable", out, 180);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold_release_done", done, 0);
    @(posedge clk); #1;
    check("hold_idle_done", done, 0);
`endif

    // Asynchronous reset in the middle of an accumulation.
    do_op(4'd3, ref_sum(3), "pre_abort");
    @(negedge clk);
    start = 1'b1;
    start_address = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("abort_out", out, 0);
    check("abort_done", done, 0);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
      check("abort_out_zero", out, 0);
    end
    do_op(4'd4, 260, "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
